apb_req_arbiter: RTL and testbench

//  Shares one APB master port among NUM_REQ independent requesters.
//  - Round-robin arbitration between requesters.
//  - Sequences IDLE->SETUP->ACCESS APB transfers and routes the response to the owning requester.
//  - Wait-state timeout aborts a hung slave.
//  - Sits between local register clients and the APB slave fabric (e.g. the add slave).

---
 rtl/apb_req_arbiter_pkg.sv | 22 ++
 rtl/apb_req_arbiter_rr.sv | 59 +++++
 rtl/apb_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter_pkg
//   Shared types and helpers for the APB request arbiter:
//   - apb_arb_state_t : APB transfer sequencer states (IDLE/SETUP/ACCESS)
//   - idx_width()     : index/counter width for a given range, never below 1
// -----------------------------------------------------------------------------
package apb_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2
    } apb_arb_state_t;

    localparam int unsigned NUM_REQ_DEFAULT = 4;

    // Width needed to hold values 0..n-1 (owner index, wait counter).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_req_arbiter_rr.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter_rr
//   Round-robin picker. Combinationally selects the first asserted request
//   scanning upward from the priority pointer (wrapping), and advances the
//   pointer to winner+1 when grant_en_i is high.
// Ports
//   clk_i, rst_i  : clock, asynchronous active-high reset (pointer -> 0)
//   req_i         : request vector
//   grant_en_i    : commit the current pick (advance pointer)
//   gnt_o         : one-hot winner (all zero when no request)
//   gnt_idx_o     : binary winner index
// -----------------------------------------------------------------------------
module apb_req_arbiter_rr
    import apb_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned IW      = idx_width(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               grant_en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      gnt_idx_o
);

    logic [IW-1:0]        ptr_q, ptr_d;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 found;
    int unsigned          win;

    always_comb begin
        // Rotate so the pointer position lands at bit 0; the first set bit
        // of the rotated vector is the winner's distance from the pointer.
        req_dbl = {req_i, req_i};
        req_rot = NUM_REQ'(req_dbl >> ptr_q);
        found   = 1'b0;
        win     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                win   = (32'(ptr_q) + i) % NUM_REQ;
            end
        end
        gnt_o     = found ? (NUM_REQ'(1) << win) : '0;
        gnt_idx_o = IW'(win);
        ptr_d     = (grant_en_i && found) ? IW'((win + 1) % NUM_REQ) : ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//   Shares one APB master port among NUM_REQ requesters with round-robin
//   arbitration, runs IDLE->SETUP->ACCESS transfers, routes the response to
//   the owning requester and aborts a slave that stalls too long.
// Ports
//   pclk, preset       : clock, asynchronous active-high reset
//   req_valid_i/write/addr/wdata : per-requester request (addr/wdata packed)
//   req_ready_o        : one-hot grant pulse (fields sampled this cycle)
//   rsp_valid_o        : one-hot response pulse to the owner
//   rsp_rdata_o/err_o  : response data / timeout flag, held until next response
//   busy_o             : transfer in SETUP/ACCESS
//   psel_o..pwdata_o   : APB master outputs
//   prdata_i, pready_i : APB slave response
// -----------------------------------------------------------------------------
module apb_req_arbiter
    import apb_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = NUM_REQ_DEFAULT,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [NUM_REQ-1:0]    req_write_i,
    input  logic [NUM_REQ*AW-1:0] req_addr_i,
    input  logic [NUM_REQ*DW-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [DW-1:0]         rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [AW-1:0]         paddr_o,
    output logic [DW-1:0]         pwdata_o,
    input  logic [DW-1:0]         prdata_i,
    input  logic                  pready_i
);

    localparam int unsigned IW = idx_width(NUM_REQ);
    localparam int unsigned CW = idx_width(TIMEOUT_CYC);

    apb_arb_state_t     state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic               write_q, write_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [CW-1:0]      wait_q, wait_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] arb_req, arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_en;
    logic               at_limit;

    // Requests are only presented to the picker in IDLE, so a grant (and a
    // pointer advance) can only happen there.
    always_comb begin
        arb_req = (state_q == ARB_IDLE) ? req_valid_i : '0;
        arb_en  = |arb_req;
    end

    apb_req_arbiter_rr #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .clk_i      (pclk),
        .rst_i      (preset),
        .req_i      (arb_req),
        .grant_en_i (arb_en),
        .gnt_o      (arb_gnt),
        .gnt_idx_o  (arb_idx)
    );

    // Limit reached on the TIMEOUT_CYC-th consecutive stalled ACCESS cycle.
    always_comb begin
        at_limit = (TIMEOUT_CYC != 0) && ((32'(wait_q) + 1) == TIMEOUT_CYC);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_d      = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (arb_en) begin
                    owner_d = arb_idx;
                    write_d = req_write_i[arb_idx];
                    addr_d  = AW'(req_addr_i >> (32'(arb_idx) * AW));
                    wdata_d = DW'(req_wdata_i >> (32'(arb_idx) * DW));
                    state_d = ARB_SETUP;
                end
            end
            ARB_SETUP: begin
                state_d = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                if (pready_i || at_limit) begin
                    // Normal completion wins over a coincident timeout.
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rsp_err_d   = !pready_i;
                    rsp_rdata_d = (pready_i && !write_q) ? prdata_i : '0;
                    // Clearing the request registers keeps the bus at 0 in IDLE.
                    write_d     = 1'b0;
                    addr_d      = '0;
                    wdata_d     = '0;
                    state_d     = ARB_IDLE;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        req_ready_o = arb_gnt;
        rsp_valid_o = rsp_valid_q;
        rsp_rdata_o = rsp_rdata_q;
        rsp_err_o   = rsp_err_q;
        psel_o      = (state_q != ARB_IDLE);
        penable_o   = (state_q == ARB_ACCESS);
        busy_o      = (state_q != ARB_IDLE);
        pwrite_o    = write_q;
        paddr_o     = addr_q;
        pwdata_o    = wdata_q;
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_req_arbiter
//   Self-checking bench for apb_req_arbiter (NUM_REQ=4, 32-bit bus,
//   TIMEOUT_CYC=16). Inputs change on the falling edge; outputs are sampled
//   1 time unit later.
// -----------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            pclk = 1'b0;
    logic            preset = 1'b1;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_write_i = '0;
    logic [N*AW-1:0] req_addr_i = '0;
    logic [N*DW-1:0] req_wdata_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N-1:0]    rsp_valid_o;
    logic [DW-1:0]   rsp_rdata_o;
    logic            rsp_err_o;
    logic            busy_o;
    logic            psel_o;
    logic            penable_o;
    logic            pwrite_o;
    logic [AW-1:0]   paddr_o;
    logic [DW-1:0]   pwdata_o;
    logic [DW-1:0]   prdata_i = '0;
    logic            pready_i = 1'b0;

    apb_req_arbiter #(
        .NUM_REQ     (N),
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .req_valid_i (req_valid_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // APB slave: inserts slave_waits wait states, or never answers when -1.
    int            slave_waits = 0;
    logic [DW-1:0] slave_rdata = '0;
    int            wcnt = 0;
    always @(negedge pclk) begin
        if (psel_o && penable_o) begin
            pready_i = (slave_waits >= 0) && (wcnt == slave_waits);
            wcnt++;
        end else begin
            pready_i = 1'b0;
            wcnt     = 0;
        end
        prdata_i = slave_rdata;
    end

    // Reference round-robin: first requester at or after the pointer, wrapping.
    int model_ptr = 0;
    function automatic int model_pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    typedef struct {
        logic [N-1:0] mask;
        logic         write;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [31:0]  rdata;
        int           waits;
        int           exp_g;
        logic [31:0]  exp_rdata;
        logic         exp_err;
        int           exp_pen;
    } xvec_t;

    task automatic do_reset();
        @(negedge pclk);
        preset      = 1'b1;
        req_valid_i = '0;
        slave_waits = 0;
        repeat (2) @(negedge pclk);
        preset    = 1'b0;
        model_ptr = 0;
    endtask

    // Requester i sees addr ^ (i<<28) and wdata ^ i so the captured fields
    // identify which requester won.
    task automatic do_xfer(input xvec_t v, input string tag);
        int            pen = 0;
        int            lat = 0;
        logic [31:0]   exp_addr;
        logic [31:0]   exp_wdata;
        logic [N-1:0]  one;
        exp_addr  = v.addr ^ (32'(v.exp_g) << 28);
        exp_wdata = v.wdata ^ 32'(v.exp_g);
        one       = N'(1) << v.exp_g;
        slave_waits = v.waits;
        slave_rdata = v.rdata;
        @(negedge pclk);
        req_valid_i = v.mask;
        req_write_i = {N{v.write}};
        for (int i = 0; i < N; i++) begin
            req_addr_i[i*AW +: AW]  = v.addr ^ (32'(i) << 28);
            req_wdata_i[i*DW +: DW] = v.wdata ^ 32'(i);
        end
        #1;
        chk({tag, "_grant"}, 64'(req_ready_o), 64'(one));
        chk({tag, "_idle_psel"}, 64'(psel_o), 0);
        @(negedge pclk);
        // Withdraw and scramble: fields after grant must not matter.
        req_valid_i = '0;
        req_write_i = ~req_write_i;
        req_addr_i  = '1;
        req_wdata_i = '1;
        #1;
        chk({tag, "_setup_sel"}, 64'({psel_o, penable_o, busy_o}), 64'(3'b101));
        chk({tag, "_setup_addr"}, 64'(paddr_o), 64'(exp_addr));
        chk({tag, "_setup_wr"}, 64'(pwrite_o), 64'(v.write));
        chk({tag, "_setup_wdata"}, 64'(pwdata_o), 64'(exp_wdata));
        for (int k = 2; k < 64; k++) begin
            @(negedge pclk);
            #1;
            if (rsp_valid_o != '0) begin
                lat = k;
                break;
            end
            if (penable_o) pen++;
            chk({tag, "_access_addr"}, 64'(paddr_o), 64'(exp_addr));
        end
        chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'(one));
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata_o), 64'(v.exp_rdata));
        chk({tag, "_rsp_err"}, 64'(rsp_err_o), 64'(v.exp_err));
        chk({tag, "_penable_cycles"}, 64'(pen), 64'(v.exp_pen));
        chk({tag, "_latency"}, 64'(lat), 64'(v.exp_pen + 2));
        chk({tag, "_idle_bus"}, 64'({psel_o, penable_o, paddr_o}), 0);
        @(negedge pclk);
        #1;
        chk({tag, "_rsp_pulse"}, 64'(rsp_valid_o), 0);
        chk({tag, "_rsp_hold"}, 64'({rsp_err_o, rsp_rdata_o}), 64'({v.exp_err, v.exp_rdata}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        xvec_t tbl[8];
        int    ngr;
        int    bad;
        int    got;
        xvec_t rv;

        // Expected grants follow the pointer from reset (0): 2,2,0,3,0,0,1,2.
        tbl[0] = '{4'b0100, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 32'h5555_5555, 0,  2, 32'h0,         1'b0, 1};
        tbl[1] = '{4'b0100, 1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678, 2,  2, 32'h1234_5678, 1'b0, 3};
        tbl[2] = '{4'b0101, 1'b0, 32'h0000_0100, 32'h1,         32'hA5A5_0F0F, 0,  0, 32'hA5A5_0F0F, 1'b0, 1};
        tbl[3] = '{4'b1001, 1'b1, 32'h0000_0200, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1,  3, 32'h0,         1'b0, 2};
        tbl[4] = '{4'b1111, 1'b0, 32'h0000_0300, 32'h2,         32'h0000_0001, 0,  0, 32'h0000_0001, 1'b0, 1};
        tbl[5] = '{4'b0001, 1'b0, 32'h0000_0400, 32'h3,         32'h7777_7777, -1, 0, 32'h0,         1'b1, TO};
        tbl[6] = '{4'b0010, 1'b0, 32'h0000_0500, 32'h4,         32'h0CAF_EF00, 0,  1, 32'h0CAF_EF00, 1'b0, 1};
        tbl[7] = '{4'b1100, 1'b0, 32'h0000_0600, 32'h5,         32'h8000_0001, 3,  2, 32'h8000_0001, 1'b0, 4};

        // Reset values
        #12;
        chk("reset_apb", 64'({psel_o, penable_o, busy_o, pwrite_o}), 0);
        chk("reset_addr_data", 64'({paddr_o, pwdata_o}), 0);
        chk("reset_rsp", 64'({rsp_valid_o, rsp_err_o, rsp_rdata_o}), 0);
        chk("reset_ready", 64'(req_ready_o), 0);
        @(negedge pclk);
        preset = 1'b0;

        for (int t = 0; t < 8; t++) begin
            do_xfer(tbl[t], $sformatf("tbl%0d", t));
        end

        // Continuous requests from reset: strict rotation 0,1,2,3,...
        do_reset();
        slave_waits = 0;
        req_valid_i = '1;
        ngr = 0;
        for (int k = 0; k < 100 && ngr < 12; k++) begin
            #1;
            if (req_ready_o != '0) begin
                chk("rr_order", 64'(req_ready_o), 64'(N'(1) << (ngr % N)));
                ngr++;
            end
            @(negedge pclk);
        end
        chk("rr_grant_count", 64'(ngr), 12);
        req_valid_i = '0;
        repeat (5) @(negedge pclk);

        // Reset during ACCESS: bus drops at once, no response, pointer back to 0.
        do_reset();
        slave_waits = -1;
        req_valid_i = 4'b0010;
        #1;
        chk("rstacc_grant", 64'(req_ready_o), 64'(4'b0010));
        @(negedge pclk);
        req_valid_i = '0;
        repeat (3) @(negedge pclk);
        #1;
        chk("rstacc_in_access", 64'({psel_o, penable_o}), 64'(2'b11));
        preset = 1'b1;
        #1;
        chk("rstacc_async_drop", 64'({psel_o, penable_o, busy_o}), 0);
        bad = 0;
        repeat (3) begin
            @(negedge pclk);
            #1;
            if (rsp_valid_o != '0) bad++;
        end
        chk("rstacc_no_rsp", 64'(bad), 0);
        @(negedge pclk);
        preset      = 1'b0;
        slave_waits = 0;
        req_valid_i = '1;
        #1;
        chk("rstacc_ptr_reset", 64'(req_ready_o), 64'(4'b0001));
        @(negedge pclk);
        req_valid_i = '0;
        repeat (5) @(negedge pclk);

        // Requester 1 asserts while 3 is in flight, then withdraws before grant.
        do_reset();
        slave_waits = 4;
        req_valid_i = 4'b1000;
        #1;
        chk("wd_grant3", 64'(req_ready_o), 64'(4'b1000));
        @(negedge pclk);
        req_valid_i = 4'b0010;
        bad = 0;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready_o[1] || rsp_valid_o[1]) bad++;
            if (rsp_valid_o == 4'b1000 && !rsp_err_o) got++;
            if (k == 3) req_valid_i = '0;
            @(negedge pclk);
        end
        chk("wd_req1_silent", 64'(bad), 0);
        chk("wd_req3_rsp", 64'(got), 1);

        // Randomized transfers against the reference round-robin model.
        do_reset();
        for (int t = 0; t < 40; t++) begin
            rv.mask      = N'($urandom_range(1, (1 << N) - 1));
            rv.write     = 1'($urandom_range(0, 1));
            rv.addr      = {4'h0, 28'($urandom)};
            rv.wdata     = $urandom;
            rv.rdata     = $urandom;
            rv.waits     = int'($urandom_range(0, 3));
            rv.exp_g     = model_pick(rv.mask);
            rv.exp_rdata = rv.write ? 32'h0 : rv.rdata;
            rv.exp_err   = 1'b0;
            rv.exp_pen   = rv.waits + 1;
            do_xfer(rv, $sformatf("rnd%0d", t));
            model_ptr = (rv.exp_g + 1) % N;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
